// File: rtl/drift_pkg.sv
// Shared definitions for the section drift monitor.
//   state_e    : monitor phases (learning baseline, watching, drift latched)
//   sat_sample : clamps a raw correct count to the section size
package drift_pkg;

  typedef enum logic [1:0] {
    ST_WARMUP  = 2'd0,
    ST_MONITOR = 2'd1,
    ST_DRIFT   = 2'd2
  } state_e;

  // A section can never have more correct inferences than it has inferences,
  // so anything above the section size is treated as a corrupted count.
  function automatic logic [31:0] sat_sample(input logic [31:0] count,
                                             input logic [31:0] size);
    return (count > size) ? size : count;
  endfunction

endpackage

// File: rtl/warmup_averager.sv
// Averages the first 2**LOG2_WARMUP accepted samples.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   restart       : drop any partial sum and restart counting
//   sample_valid  : sample is accepted this cycle (already qualified by caller)
//   sample        : saturated sample value
//   done          : combinational, high on the cycle of the final warmup sample
//   avg           : combinational average including the current sample
module warmup_averager #(
  parameter int COUNT_W     = 8,
  parameter int LOG2_WARMUP = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restart,
  input  logic               sample_valid,
  input  logic [COUNT_W-1:0] sample,
  output logic               done,
  output logic [COUNT_W-1:0] avg
);

  localparam int SUM_W = COUNT_W + LOG2_WARMUP;
  // One spare bit keeps the counter legal when LOG2_WARMUP is 0.
  localparam int CNT_W = LOG2_WARMUP + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << LOG2_WARMUP) - 1);

  logic [SUM_W-1:0] sum_q, sum_d, sum_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sum_next = sum_q + SUM_W'(sample);
    done     = sample_valid && (cnt_q == LAST);
    avg      = COUNT_W'(sum_next >> LOG2_WARMUP);
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    if (restart) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (sample_valid) begin
      if (done) begin
        sum_d = '0;
        cnt_d = '0;
      end else begin
        sum_d = sum_next;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/section_drift_monitor.sv
// Learns a baseline section accuracy, then latches a sticky drift flag when
// accuracy stays more than THRESHOLD below it for CONFIRM_SECTIONS sections.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   clear            : restart warmup and zero all status
//   rebaseline       : restart warmup, keep section_count/drift_section/baseline
//   section_valid    : one-cycle strobe per finished section
//   section_correct  : correct count of that section
//   monitor_active   : baseline learned, monitoring running
//   drift            : sticky drift flag
//   drift_section    : section_count of the section that confirmed drift
//   baseline         : learned baseline
//   last_correct     : last accepted (saturated) sample
//   low_run          : consecutive low sections
//   section_count    : sections accepted since clear
module section_drift_monitor
  import drift_pkg::*;
#(
  parameter int COUNT_W          = 8,
  parameter int SECTION_SIZE     = 100,
  parameter int LOG2_WARMUP      = 2,
  parameter int THRESHOLD        = 10,
  parameter int CONFIRM_SECTIONS = 2,
  parameter int IDX_W            = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               rebaseline,
  input  logic               section_valid,
  input  logic [COUNT_W-1:0] section_correct,
  output logic               monitor_active,
  output logic               drift,
  output logic [IDX_W-1:0]   drift_section,
  output logic [COUNT_W-1:0] baseline,
  output logic [COUNT_W-1:0] last_correct,
  output logic [IDX_W-1:0]   low_run,
  output logic [IDX_W-1:0]   section_count
);

  state_e             state_q, state_d;
  logic               active_q, active_d;
  logic               drift_q, drift_d;
  logic [IDX_W-1:0]   dsec_q, dsec_d;
  logic [COUNT_W-1:0] base_q, base_d;
  logic [COUNT_W-1:0] last_q, last_d;
  logic [IDX_W-1:0]   lrun_q, lrun_d;
  logic [IDX_W-1:0]   scnt_q, scnt_d;

  logic [COUNT_W-1:0] s;
  logic               is_low;
  logic [IDX_W-1:0]   lrun_next;
  logic [IDX_W-1:0]   scnt_next;
  logic               warm_valid, warm_done;
  logic [COUNT_W-1:0] warm_avg;

  assign s = COUNT_W'(sat_sample(32'(section_correct), 32'(SECTION_SIZE)));

  // One extra bit so s + THRESHOLD cannot wrap and look small.
  assign is_low    = ({1'b0, s} + (COUNT_W+1)'(THRESHOLD)) < {1'b0, base_q};
  assign lrun_next = !is_low ? '0 : ((&lrun_q) ? lrun_q : lrun_q + 1'b1);
  assign scnt_next = scnt_q + 1'b1;

  // Strobes colliding with clear/rebaseline are dropped, so they never
  // reach the averager either.
  assign warm_valid = section_valid && (state_q == ST_WARMUP) && !clear && !rebaseline;

  warmup_averager #(
    .COUNT_W    (COUNT_W),
    .LOG2_WARMUP(LOG2_WARMUP)
  ) u_warmup (
    .clk         (clk),
    .reset       (reset),
    .restart     (clear | rebaseline),
    .sample_valid(warm_valid),
    .sample      (s),
    .done        (warm_done),
    .avg         (warm_avg)
  );

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    drift_d  = drift_q;
    dsec_d   = dsec_q;
    base_d   = base_q;
    last_d   = last_q;
    lrun_d   = lrun_q;
    scnt_d   = scnt_q;
    if (clear) begin
      state_d  = ST_WARMUP;
      active_d = 1'b0;
      drift_d  = 1'b0;
      dsec_d   = '0;
      base_d   = '0;
      last_d   = '0;
      lrun_d   = '0;
      scnt_d   = '0;
    end else if (rebaseline) begin
      // Old baseline stays visible until the new warmup finishes.
      state_d  = ST_WARMUP;
      active_d = 1'b0;
      drift_d  = 1'b0;
      lrun_d   = '0;
    end else if (section_valid) begin
      last_d = s;
      scnt_d = scnt_next;
      unique case (state_q)
        ST_WARMUP: begin
          if (warm_done) begin
            base_d   = warm_avg;
            active_d = 1'b1;
            state_d  = ST_MONITOR;
          end
        end
        ST_MONITOR: begin
          lrun_d = lrun_next;
          if (lrun_next == IDX_W'(CONFIRM_SECTIONS)) begin
            drift_d = 1'b1;
            dsec_d  = scnt_next;
            state_d = ST_DRIFT;
          end
        end
        ST_DRIFT: lrun_d = lrun_next;
        default:  state_d = ST_WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_WARMUP;
      active_q <= 1'b0;
      drift_q  <= 1'b0;
      dsec_q   <= '0;
      base_q   <= '0;
      last_q   <= '0;
      lrun_q   <= '0;
      scnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      drift_q  <= drift_d;
      dsec_q   <= dsec_d;
      base_q   <= base_d;
      last_q   <= last_d;
      lrun_q   <= lrun_d;
      scnt_q   <= scnt_d;
    end
  end

  assign monitor_active = active_q;
  assign drift          = drift_q;
  assign drift_section  = dsec_q;
  assign baseline       = base_q;
  assign last_correct   = last_q;
  assign low_run        = lrun_q;
  assign section_count  = scnt_q;

endmodule

// File: tb/tb_section_drift_monitor.sv
module tb_section_drift_monitor;

  logic       clk = 1'b0;
  logic       reset, clear, rebaseline, section_valid;
  logic [7:0] section_correct;
  logic       monitor_active, drift;
  logic [9:0] drift_section, low_run, section_count;
  logic [7:0] baseline, last_correct;

  typedef struct packed {
    logic       active;
    logic       drift;
    logic [9:0] dsec;
    logic [7:0] base;
    logic [7:0] last;
    logic [9:0] lrun;
    logic [9:0] scnt;
  } snap_t;

  snap_t sb[$];
  snap_t m;
  int    m_state, m_sum, m_cnt;
  int    n_tests = 0;
  int    n_fail  = 0;

  section_drift_monitor dut (
    .clk            (clk),
    .reset          (reset),
    .clear          (clear),
    .rebaseline     (rebaseline),
    .section_valid  (section_valid),
    .section_correct(section_correct),
    .monitor_active (monitor_active),
    .drift          (drift),
    .drift_section  (drift_section),
    .baseline       (baseline),
    .last_correct   (last_correct),
    .low_run        (low_run),
    .section_count  (section_count)
  );

  always #5 clk = ~clk;

  // Reference behaviour: WARMUP=0, MONITOR=1, DRIFT=2; 4 warmup sections,
  // threshold 10, confirm 2, ceiling 100.
  task automatic model_apply(input logic rst, input logic clr, input logic rb,
                             input logic v, input int c);
    int  sv;
    bit  low;
    if (rst || clr) begin
      m = '0; m_state = 0; m_sum = 0; m_cnt = 0;
    end else if (rb) begin
      m_state = 0; m.active = 0; m.drift = 0; m.lrun = 0; m_sum = 0; m_cnt = 0;
    end else if (v) begin
      sv = (c > 100) ? 100 : c;
      m.last = sv[7:0];
      m.scnt = m.scnt + 10'd1;
      if (m_state == 0) begin
        m_sum += sv;
        m_cnt++;
        if (m_cnt == 4) begin
          m.base   = 8'(m_sum / 4);
          m.active = 1;
          m_state  = 1;
          m_sum    = 0;
          m_cnt    = 0;
        end
      end else begin
        low = (sv + 10) < int'(m.base);
        if (!low)                m.lrun = 0;
        else if (m.lrun != 1023) m.lrun = m.lrun + 10'd1;
        if (m_state == 1 && m.lrun == 2) begin
          m.drift = 1;
          m.dsec  = m.scnt;
          m_state = 2;
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic clr, input logic rb,
                      input logic v, input int c);
    @(negedge clk);
    reset = rst; clear = clr; rebaseline = rb; section_valid = v;
    section_correct = 8'(c);
    model_apply(rst, clr, rb, v, c);
    sb.push_back(m);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: every driven cycle has one expected snapshot, compared
  // shortly after the edge that consumes it.
  always begin
    snap_t e, g;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      g = '{monitor_active, drift, drift_section, baseline, last_correct,
            low_run, section_count};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL sb t=%0t got act=%0b drf=%0b dsec=%0d base=%0d last=%0d lrun=%0d scnt=%0d exp act=%0b drf=%0b dsec=%0d base=%0d last=%0d lrun=%0d scnt=%0d",
                 $time, g.active, g.drift, g.dsec, g.base, g.last, g.lrun, g.scnt,
                 e.active, e.drift, e.dsec, e.base, e.last, e.lrun, e.scnt);
      end
    end
  end

  task automatic test_reset;
    step(1, 0, 0, 0, 0);
    n_tests++;
    if ({monitor_active, drift, drift_section, baseline, last_correct, low_run, section_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_zero got base=%0d scnt=%0d drift=%0b exp all 0", baseline, section_count, drift);
    end
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_warmup;
    int vals[4] = '{90, 92, 88, 94};
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, vals[i]);
      if (i == 2) begin
        n_tests++;
        if (monitor_active !== 1'b0) begin
          n_fail++; $display("FAIL warmup_early_active got %0b exp 0", monitor_active);
        end
      end
    end
    n_tests++;
    if (baseline !== 8'd91 || monitor_active !== 1'b1 || drift !== 1'b0 || section_count !== 10'd4) begin
      n_fail++;
      $display("FAIL warmup_done got base=%0d act=%0b drift=%0b scnt=%0d exp 91 1 0 4",
               baseline, monitor_active, drift, section_count);
    end
  endtask

  task automatic test_confirm_drift;
    step(0, 0, 0, 1, 80);
    n_tests++;
    if (low_run !== 10'd1 || drift !== 1'b0) begin
      n_fail++; $display("FAIL confirm_first got lrun=%0d drift=%0b exp 1 0", low_run, drift);
    end
    step(0, 0, 0, 1, 75);
    n_tests++;
    if (low_run !== 10'd2 || drift !== 1'b1 || drift_section !== 10'd6) begin
      n_fail++; $display("FAIL confirm_drift got lrun=%0d drift=%0b dsec=%0d exp 2 1 6", low_run, drift, drift_section);
    end
    step(0, 0, 0, 1, 95);
    n_tests++;
    if (low_run !== 10'd0 || drift !== 1'b1 || drift_section !== 10'd6) begin
      n_fail++; $display("FAIL drift_sticky got lrun=%0d drift=%0b dsec=%0d exp 0 1 6", low_run, drift, drift_section);
    end
    step(0, 0, 0, 1, 40);
    step(0, 0, 0, 1, 40);
    n_tests++;
    if (drift_section !== 10'd6 || low_run !== 10'd2) begin
      n_fail++; $display("FAIL dsec_frozen got dsec=%0d lrun=%0d exp 6 2", drift_section, low_run);
    end
  endtask

  task automatic test_nonconsecutive;
    int vals[4] = '{80, 85, 80, 81};
    int exp_l[4] = '{1, 0, 1, 0};
    step(0, 1, 0, 0, 0);
    test_warmup();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, vals[i]);
      n_tests++;
      if (low_run !== 10'(exp_l[i]) || drift !== 1'b0) begin
        n_fail++; $display("FAIL nonconsec_%0d got lrun=%0d drift=%0b exp %0d 0", i, low_run, drift, exp_l[i]);
      end
    end
  endtask

  task automatic test_saturation;
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 200);
    n_tests++;
    if (last_correct !== 8'd100) begin
      n_fail++; $display("FAIL sat_last got %0d exp 100", last_correct);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 100);
    n_tests++;
    if (baseline !== 8'd100) begin
      n_fail++; $display("FAIL sat_base got %0d exp 100", baseline);
    end
  endtask

  task automatic test_clear_collision;
    step(0, 1, 0, 0, 0);
    test_warmup();
    step(0, 0, 0, 1, 50);
    step(0, 0, 0, 1, 50);
    n_tests++;
    if (drift !== 1'b1) begin
      n_fail++; $display("FAIL clr_setup got drift=%0b exp 1", drift);
    end
    step(0, 1, 0, 1, 90);
    n_tests++;
    if ({monitor_active, drift, drift_section, baseline, last_correct, low_run, section_count} !== '0) begin
      n_fail++; $display("FAIL clr_collide got scnt=%0d last=%0d drift=%0b exp 0 0 0", section_count, last_correct, drift);
    end
    // The dropped strobe must not count: four more samples are still needed.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 60);
    n_tests++;
    if (monitor_active !== 1'b0) begin
      n_fail++; $display("FAIL clr_discard got act=%0b exp 0", monitor_active);
    end
  endtask

  task automatic test_rebaseline;
    step(0, 1, 0, 0, 0);
    test_warmup();
    step(0, 0, 0, 1, 80);
    step(0, 0, 0, 1, 75);
    step(0, 0, 0, 1, 95);
    step(0, 0, 1, 1, 10);
    n_tests++;
    if (drift !== 1'b0 || monitor_active !== 1'b0 || baseline !== 8'd91 || section_count !== 10'd7 || drift_section !== 10'd6) begin
      n_fail++; $display("FAIL rebase_enter got drift=%0b act=%0b base=%0d scnt=%0d dsec=%0d exp 0 0 91 7 6",
                         drift, monitor_active, baseline, section_count, drift_section);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 70);
      n_tests++;
      if (baseline !== ((i == 3) ? 8'd70 : 8'd91) || section_count !== 10'(8 + i)) begin
        n_fail++; $display("FAIL rebase_%0d got base=%0d scnt=%0d exp %0d %0d",
                           i, baseline, section_count, (i == 3) ? 70 : 91, 8 + i);
      end
    end
  endtask

  task automatic test_reset_midwarmup;
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 90);
    step(0, 0, 0, 1, 92);
    step(1, 0, 0, 1, 88);
    n_tests++;
    if ({monitor_active, drift, drift_section, baseline, last_correct, low_run, section_count} !== '0) begin
      n_fail++; $display("FAIL reset_mid got scnt=%0d last=%0d exp 0 0", section_count, last_correct);
    end
  endtask

  task automatic test_low_baseline;
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 5);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    n_tests++;
    if (baseline !== 8'd5 || drift !== 1'b0 || low_run !== 10'd0) begin
      n_fail++; $display("FAIL low_base got base=%0d drift=%0b lrun=%0d exp 5 0 0", baseline, drift, low_run);
    end
  endtask

  initial begin
    reset = 1; clear = 0; rebaseline = 0; section_valid = 0; section_correct = '0;
    m = '0; m_state = 0; m_sum = 0; m_cnt = 0;
    test_reset();
    test_warmup();
    test_confirm_drift();
    test_nonconsecutive();
    test_saturation();
    test_clear_collision();
    test_rebaseline();
    test_reset_midwarmup();
    test_low_baseline();
    step(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_drain got %0d pending exp 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
